// File: rtl/lt24_touch_reader.sv
// Touch-ADC serial master for the LT24 panel (ADS7843-style). While the pen is down it converts
// X then Y in one chip-select frame, scales the raw results to pixels and pulses touch_valid.
module lt24_touch_reader #(
  parameter int          CLK_DIV = 25,
  parameter int          HOLDOFF = 500000,
  parameter logic [7:0]  CMD_X   = 8'hD0,
  parameter logic [7:0]  CMD_Y   = 8'h90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        LT24_ADC_PENIRQ_N,
  input  logic        LT24_ADC_BUSY,
  input  logic        LT24_ADC_DOUT,
  output logic        LT24_ADC_CS_N,
  output logic        LT24_ADC_DCLK,
  output logic        LT24_ADC_DIN,
  output logic [11:0] touch_raw_x,
  output logic [11:0] touch_raw_y,
  output logic [10:0] touch_pos_x,
  output logic [10:0] touch_pos_y,
  output logic        touch_valid,
  output logic        touch_pressed,
  output logic        scan_busy
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CONV_X, S_CONV_Y, S_DONE, S_WAIT} state_t;

  state_t             state, state_next;
  logic               pen_meta, pen_n_s;
  logic [DIV_W-1:0]   div_cnt;
  logic [5:0]         tgl_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [15:0]        shift;
  logic [11:0]        x_tmp;
  logic               in_conv, div_tc, conv_end, hold_tc, start;
  logic [5:0]         fall_k;
  logic [7:0]         cmd_bits;
  logic               unused_inputs;

  // BUSY is status only; the top shift bit is the ADC's null/busy slot and is never published.
  assign unused_inputs = LT24_ADC_BUSY ^ shift[15];

  assign scan_busy = ~LT24_ADC_CS_N;

  always_comb begin
    in_conv  = (state == S_CONV_X) || (state == S_CONV_Y);
    div_tc   = in_conv && (div_cnt == DIV_W'(CLK_DIV - 1));
    conv_end = div_tc && (tgl_cnt == 6'd47);
    hold_tc  = (hold_cnt == HOLD_W'(HOLDOFF - 1));
    start    = enable && !pen_n_s;
    // Falling edge k happens on toggle 2k-1; DIN then carries the bit for rising edge k+1.
    fall_k   = (tgl_cnt + 6'd1) >> 1;
    cmd_bits = (state == S_CONV_X) ? CMD_X : CMD_Y;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = start ? S_CONV_X : S_IDLE;
      S_CONV_X: state_next = conv_end ? S_CONV_Y : S_CONV_X;
      S_CONV_Y: state_next = conv_end ? S_DONE : S_CONV_Y;
      S_DONE:   state_next = S_WAIT;
      S_WAIT:   state_next = hold_tc ? S_IDLE : S_WAIT;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pen_meta      <= 1'b1;
      pen_n_s       <= 1'b1;
      div_cnt       <= '0;
      tgl_cnt       <= 6'd0;
      hold_cnt      <= '0;
      shift         <= 16'd0;
      x_tmp         <= 12'd0;
      LT24_ADC_CS_N <= 1'b1;
      LT24_ADC_DCLK <= 1'b0;
      LT24_ADC_DIN  <= 1'b0;
      touch_raw_x   <= 12'd0;
      touch_raw_y   <= 12'd0;
      touch_pos_x   <= 11'd0;
      touch_pos_y   <= 11'd0;
      touch_valid   <= 1'b0;
      touch_pressed <= 1'b0;
    end else begin
      pen_meta    <= LT24_ADC_PENIRQ_N;
      pen_n_s     <= pen_meta;
      touch_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          div_cnt  <= '0;
          tgl_cnt  <= 6'd0;
          hold_cnt <= '0;
          if (start) begin
            LT24_ADC_CS_N <= 1'b0;
            LT24_ADC_DIN  <= CMD_X[7];
            touch_pressed <= 1'b1;
          end else if (pen_n_s) begin
            touch_pressed <= 1'b0;
          end
        end
        S_CONV_X, S_CONV_Y: begin
          if (div_tc) begin
            div_cnt       <= '0;
            tgl_cnt       <= tgl_cnt + 6'd1;
            LT24_ADC_DCLK <= ~LT24_ADC_DCLK;
            // Rising edges 9..24 are toggles 16..46 (even).
            if (!LT24_ADC_DCLK && (tgl_cnt >= 6'd16)) shift <= {shift[14:0], LT24_ADC_DOUT};
            if (LT24_ADC_DCLK) begin
              if (fall_k < 6'd8) LT24_ADC_DIN <= cmd_bits[3'd7 - fall_k[2:0]];
              else               LT24_ADC_DIN <= 1'b0;
            end
            if (conv_end) begin
              tgl_cnt <= 6'd0;
              if (state == S_CONV_X) begin
                x_tmp        <= shift[14:3];
                LT24_ADC_DIN <= CMD_Y[7];
              end else begin
                LT24_ADC_CS_N <= 1'b1;
                LT24_ADC_DIN  <= 1'b0;
                touch_valid   <= 1'b1;
                touch_raw_x   <= x_tmp;
                touch_raw_y   <= shift[14:3];
                touch_pos_x   <= 11'((20'(x_tmp) * 20'd240) >> 12);
                touch_pos_y   <= 11'((21'(shift[14:3]) * 21'd320) >> 12);
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_DONE:  hold_cnt <= '0;
        S_WAIT:  hold_cnt <= hold_cnt + HOLD_W'(1);
        default: hold_cnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/lt24_touch_reader.md
Name: lt24_touch_reader

Overview:
- SPI-style master for the LT24 touch ADC (ADS7843-compatible) on the ADC_* pins of GPIO1.
- While the pen is down, it repeatedly converts the X and Y channels, captures the 12-bit raw results and scales them to screen pixel coordinates.
- It publishes each coordinate pair with a one-cycle valid pulse, so pointer positions reach the display path without CPU bit-banging.

Parameters:
- CLK_DIV, 25, clk cycles per DCLK half-period (50 MHz clk gives a 1 MHz DCLK); legal range ≥2.
- HOLDOFF, 500000, clk cycles of idle between the end of one X/Y pair and the next PENIRQ check (10 ms at 50 MHz).
- CMD_X, 8'hD0, control byte for X: S=1, A=101, 12-bit, differential, PD=00.
- CMD_Y, 8'h90, control byte for Y: A=001.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  level; scanning allowed while high
- LT24_ADC_PENIRQ_N  in  1  pen-down, active-low, asynchronous
- LT24_ADC_BUSY  in  1  ADC busy; status only, not used for sequencing
- LT24_ADC_DOUT  in  1  ADC serial data out
- LT24_ADC_CS_N  out  1  ADC chip select, active-low
- LT24_ADC_DCLK  out  1  ADC serial clock
- LT24_ADC_DIN  out  1  ADC serial data in
- touch_raw_x  out  12  last raw X
- touch_raw_y  out  12  last raw Y
- touch_pos_x  out  11  scaled X, 0..239
- touch_pos_y  out  11  scaled Y, 0..319
- touch_valid  out  1  one-cycle pulse: new pair on outputs
- touch_pressed  out  1  level: pen considered down
- scan_busy  out  1  high while CS_N is low

Behaviour:
- Interface: one clock domain (clk); rst is synchronous and active-high.
- Reset values: CS_N=1, DCLK=0, DIN=0, all data outputs 0, touch_valid=0, touch_pressed=0, scan_busy=0, FSM in IDLE, all counters 0.
- Reset mid-transfer forces CS_N=1 and DCLK=0 on the next edge. No partial result is published.
- PENIRQ_N passes through a 2-flop synchronizer (pen_n_s) before any use. pen_n_s is evaluated only in IDLE; PENIRQ is ignored while CS_N is low.
- FSM states:
  - IDLE: if enable and pen_n_s==0, go to CONV_X, set touch_pressed=1, and drive CS_N=0 with DIN=CMD_X[7] on the same edge. If pen_n_s==1, clear touch_pressed and stay.
  - CONV_X: 24 DCLK periods, then CONV_Y directly. CS_N stays low and DIN=CMD_Y[7] is driven at the final falling edge.
  - CONV_Y: 24 DCLK periods, then DONE.
  - DONE: one cycle. CS_N=1, outputs updated, touch_valid=1. Go to WAIT.
  - WAIT: count HOLDOFF cycles, then IDLE.
- Dropping enable mid-scan completes the current pair, including its valid pulse. The FSM then stays in IDLE until enable returns.
- DCLK generation:
  - A divider counts 0..CLK_DIV-1 and toggles DCLK at terminal count, only in CONV states.
  - DCLK period is 2*CLK_DIV clk.
  - Each conversion begins with DCLK low for one half-period.
- Serial framing per conversion (rising edges k=1..24):
  - DIN is updated after each falling edge and carries cmd bit 8-k for k=1..8; DIN=0 for k≥9.
  - DOUT is sampled on rising edges k=9..24 into a 16-bit shift register, MSB first.
  - result = shift[14:3], i.e. edge 9 is the busy bit and edges 22..24 are discarded.
  - DCLK ends low after edge 24 plus one half-period.
- Scaling, with full-width products and no overflow:
  - touch_pos_x = (raw_x*240)>>12, using a 20-bit product, giving 0..239.
  - touch_pos_y = (raw_y*320)>>12, using a 21-bit product, giving 0..319.
  - Raw and scaled outputs update together in DONE and hold until the next DONE.
- Timing: CS_N low for exactly 48*2*CLK_DIV clk cycles. touch_valid is asserted in the first cycle CS_N is high.
- scan_busy equals ~CS_N.

Test Plan:
- Reset: hold rst 3 cycles with PENIRQ_N=0 → CS_N=1, DCLK=0, valid=0, pressed=0; no DCLK edges during reset.
- Single touch: ADC model returns X=0x800, Y=0x400 → DIN shifts 0xD0 then 0x90; raw_x=0x800, raw_y=0x400, pos_x=120, pos_y=80; exactly one valid pulse; CS_N low for 2400 clk at CLK_DIV=25.
- Full scale: model returns 0xFFF and 0x000 → pos_x=239, pos_y=0; swapped values → pos_x=0, pos_y=319.
- Pen lift: PENIRQ_N high during CONV_Y → pair still published. After HOLDOFF, pressed falls 3 cycles after IDLE entry, at most; no further CS_N activity.
- Enable/reset mid-scan: enable low during CONV_X → pair completes, then idle. rst during CONV_Y → CS_N=1 on next edge, no valid pulse.
- Repeat rate: pen held low, HOLDOFF=1000 → successive valid pulses exactly 2400+1000+3 clk apart, ±1 clk for the IDLE entry.
